// File: rtl/sccb_pkg.sv
// Shared SCCB master definitions: register map, FSM states and quarter-phase encoding.
package sccb_pkg;

   localparam logic [2:0] REG_CONTROL           = 3'd0;
   localparam logic [2:0] REG_SLAVE_ADDRESS     = 3'd1;
   localparam logic [2:0] REG_SLAVE_REG_ADDRESS = 3'd2;
   localparam logic [2:0] REG_SLAVE_DATA_1      = 3'd3;
   localparam logic [2:0] REG_SLAVE_DATA_2      = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_SHIFT,
      ST_ACK,
      ST_STOP,
      ST_DONE
   } sccb_state_e;

   typedef enum logic [1:0] {
      QTR_0,
      QTR_1,
      QTR_2,
      QTR_3
   } sccb_qtr_e;

   // SCL is high during the middle two quarters of every bit and ACK slot.
   function automatic logic scl_level(input sccb_qtr_e qtr);
      return (qtr == QTR_1) || (qtr == QTR_2);
   endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-period tick: one-clk pulse every CLK_DIV enabled cycles; restart_i zeroes the count.
// No backpressure; the pulse is suppressed in the restart cycle.
module sccb_tick_gen #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   assign tick_o = en_i && !restart_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sccb_master.sv
// Write-only SCCB master: 3/4-byte register write; ready drops the clk after the start write.
// Define SCCB_ACK_CHECK_EN to end a transfer early (success_out=0) on a slave NACK.
module sccb_master #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] address,
   input  logic [7:0] writedata,
   input  logic       write,
   output logic       ready,
   output logic       success_out,
   output logic       scl_out,
   output logic       sda,
   output logic       sda_oe,
   input  logic       sda_in
);

   import sccb_pkg::*;

   logic [7:0]  slave_addr_q;
   logic [7:0]  reg_addr_q;
   logic [7:0]  data1_q;
   logic [7:0]  data2_q;
   logic        two_byte_q;

   sccb_state_e state_q, state_d;
   sccb_qtr_e   qtr_q, qtr_d;
   logic [2:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic        ack_ok_q, ack_ok_d;
   logic        success_q, success_d;

   logic        tick;
   logic        start_req;
   logic        nack_sampled;
   logic [7:0]  cur_byte;
   logic [1:0]  last_byte;

   assign ready       = (state_q == ST_IDLE);
   assign success_out = success_q;
   assign start_req   = ready && write && (address == REG_CONTROL) && writedata[0];
   assign last_byte   = two_byte_q ? 2'd3 : 2'd2;

`ifdef SCCB_ACK_CHECK_EN
   assign nack_sampled = sda_in;
`else
   logic unused_sda_in;
   assign unused_sda_in = sda_in;
   assign nack_sampled  = 1'b0;
`endif

   sccb_tick_gen #(
      .CLK_DIV   (CLK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (state_q != ST_IDLE),
      .restart_i (start_req),
      .tick_o    (tick)
   );

   always_comb begin
      unique case (byte_q)
         2'd0:    cur_byte = {slave_addr_q[7:1], 1'b0};
         2'd1:    cur_byte = reg_addr_q;
         2'd2:    cur_byte = data1_q;
         default: cur_byte = data2_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slave_addr_q <= '0;
         reg_addr_q   <= '0;
         data1_q      <= '0;
         data2_q      <= '0;
         two_byte_q   <= 1'b0;
      end else if (write && ready) begin
         case (address)
            REG_CONTROL:           two_byte_q   <= writedata[1];
            REG_SLAVE_ADDRESS:     slave_addr_q <= writedata;
            REG_SLAVE_REG_ADDRESS: reg_addr_q   <= writedata;
            REG_SLAVE_DATA_1:      data1_q      <= writedata;
            REG_SLAVE_DATA_2:      data2_q      <= writedata;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      ack_ok_d  = ack_ok_q;
      success_d = success_q;
      scl_out   = 1'b1;
      sda       = 1'b1;
      sda_oe    = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               state_d  = ST_START;
               qtr_d    = QTR_0;
               bit_d    = 3'd7;
               byte_d   = 2'd0;
               ack_ok_d = 1'b1;
            end
         end
         ST_START: begin
            sda = 1'b0;
            if (tick) begin
               state_d = ST_SHIFT;
               qtr_d   = QTR_0;
            end
         end
         ST_SHIFT: begin
            scl_out = scl_level(qtr_q);
            sda     = cur_byte[bit_q];
            if (tick) begin
               qtr_d = sccb_qtr_e'(qtr_q + 2'd1);
               // bit index wraps 0 -> 7, ready for the next byte
               if (qtr_q == QTR_3) begin
                  bit_d = bit_q - 3'd1;
                  if (bit_q == 3'd0) begin
                     state_d = ST_ACK;
                  end
               end
            end
         end
         ST_ACK: begin
            scl_out = scl_level(qtr_q);
            sda_oe  = 1'b0;
            if (tick) begin
               qtr_d = sccb_qtr_e'(qtr_q + 2'd1);
               if ((qtr_q == QTR_1) && nack_sampled) begin
                  ack_ok_d = 1'b0;
               end
               if (qtr_q == QTR_3) begin
                  if ((byte_q == last_byte) || !ack_ok_q) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_SHIFT;
                     byte_d  = byte_q + 2'd1;
                  end
               end
            end
         end
         ST_STOP: begin
            scl_out = (qtr_q != QTR_0);
            sda     = (qtr_q == QTR_2);
            if (tick) begin
               qtr_d = sccb_qtr_e'(qtr_q + 2'd1);
               if (qtr_q == QTR_2) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            success_d = ack_ok_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         qtr_q     <= QTR_0;
         bit_q     <= 3'd0;
         byte_q    <= 2'd0;
         ack_ok_q  <= 1'b0;
         success_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         ack_ok_q  <= ack_ok_d;
         success_q <= success_d;
      end
   end

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: bus-level monitor rebuilds bytes from SCL pulses and compares against a register-map model.
`timescale 1ns/1ps
module tb_sccb_master;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] address;
   logic [7:0] writedata;
   logic       write;
   logic       ready;
   logic       success_out;
   logic       scl_out;
   logic       sda;
   logic       sda_oe;
   logic       sda_in = 1'b1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_reg [0:4];
   bit         m_busy = 1'b0;

   logic [1:0] mon_q [$];
   int         start_seen = 0;
   int         stop_seen  = 0;
   logic       prev_scl   = 1'b1;
   logic       prev_sda   = 1'b1;
   logic       pend_vld   = 1'b0;
   logic [1:0] pend       = 2'b00;
   int         base       = 0;
   int         nack_byte  = -1;

   always #5 clk = ~clk;

   sccb_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .writedata   (writedata),
      .write       (write),
      .ready       (ready),
      .success_out (success_out),
      .scl_out     (scl_out),
      .sda         (sda),
      .sda_oe      (sda_oe),
      .sda_in      (sda_in)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse = SCL rise followed by a fall inside a transfer; record {oe, sda} at the rise.
   always @(negedge clk) begin
      if (ready) begin
         pend_vld = 1'b0;
      end else if (scl_out && !prev_scl) begin
         pend     = {sda_oe, sda};
         pend_vld = 1'b1;
      end else if (!scl_out && prev_scl && pend_vld) begin
         mon_q.push_back(pend);
         pend_vld = 1'b0;
      end
      if (scl_out && prev_scl && sda_oe && prev_sda && !sda) start_seen++;
      if (scl_out && prev_scl && sda_oe && !prev_sda && sda) stop_seen++;
      prev_scl = scl_out;
      prev_sda = sda;
   end

   // Slave: ACK every byte except nack_byte (line pulled high when not driven low).
   always @(negedge clk) begin
      if (sda_oe) sda_in = 1'b1;
      else        sda_in = (nack_byte >= 0) && (((mon_q.size() - base) / 9) == nack_byte);
   end

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      address   = a;
      writedata = d;
      write     = 1'b1;
      if (!m_busy && a <= 3'd4) m_reg[a] = d;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic go(input bit two, input int nack, input bit busy_wr, input string tag);
      logic [7:0] eb [$];
      int         nb, np, cyc, st0, sp0, idx;
      bit         es;
      logic [7:0] b;
      logic       oe_all;
      eb = '{m_reg[1] & 8'hFE, m_reg[2], m_reg[3]};
      if (two) eb.push_back(m_reg[4]);
      nb = eb.size();
      es = 1'b1;
`ifdef SCCB_ACK_CHECK_EN
      if (nack >= 0 && nack < nb) begin
         nb = nack + 1;
         es = 1'b0;
      end
`endif
      np        = 9 * nb;
      base      = mon_q.size();
      st0       = start_seen;
      sp0       = stop_seen;
      nack_byte = nack;
      wr(3'd0, {6'd0, two, 1'b1});
      m_busy = 1'b1;
      check({tag, "_busy"}, ready, 0);
      cyc = 1;
      if (busy_wr) begin
         wr(3'd3, 8'hFF);
         wr(3'd0, 8'h01);
         cyc += 4;
      end
      while (!ready && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_ready"}, ready, 1);
      check({tag, "_latency"}, cyc, CLK_DIV * (4 + 4 * np) + 2);
      check({tag, "_success"}, success_out, es);
      check({tag, "_pulses"}, mon_q.size() - base, np);
      check({tag, "_start"}, start_seen - st0, 1);
      check({tag, "_stop"}, stop_seen - sp0, 1);
      for (int k = 0; k < nb; k++) begin
         b      = 8'h00;
         oe_all = 1'b1;
         for (int i = 0; i < 8; i++) begin
            idx = base + 9 * k + i;
            if (idx < mon_q.size()) begin
               b      = {b[6:0], mon_q[idx][0]};
               oe_all = oe_all & mon_q[idx][1];
            end
         end
         check($sformatf("%s_byte%0d", tag, k), b, eb[k]);
         check($sformatf("%s_dataoe%0d", tag, k), oe_all, 1);
         idx = base + 9 * k + 8;
         if (idx < mon_q.size()) check($sformatf("%s_ackoe%0d", tag, k), mon_q[idx][1], 0);
      end
      nack_byte = -1;
      m_busy    = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_scl"}, scl_out, 1);
      check({tag, "_sda"}, sda, 1);
      check({tag, "_oe"}, sda_oe, 1);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_success"}, success_out, 0);
   endtask

   initial begin
      int cyc;
      reset_n   = 1'b0;
      address   = 3'd0;
      writedata = 8'd0;
      write     = 1'b0;
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      wr(3'd1, 8'h60); wr(3'd2, 8'h12); wr(3'd3, 8'h80);
      go(1'b0, -1, 1'b0, "basic");
      go(1'b0, 1, 1'b0, "nack_ra");
      wr(3'd4, 8'hA5);
      go(1'b1, -1, 1'b0, "two_byte");
      wr(3'd1, 8'h61);
      go(1'b0, -1, 1'b0, "addr_lsb");
      wr(3'd5, 8'h33); wr(3'd6, 8'h44); wr(3'd7, 8'h55);
      go(1'b0, -1, 1'b1, "busy_wr");
      go(1'b0, -1, 1'b0, "after_busy");

      for (int t = 0; t < 12; t++) begin
         for (int a = 1; a <= 4; a++)
            if ($urandom_range(0, 3) != 0) wr(3'(a), 8'($urandom));
         if ($urandom_range(0, 2) == 0) wr(3'($urandom_range(5, 7)), 8'($urandom));
         go(1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
            1'b0, $sformatf("rnd%0d", t));
      end

      wr(3'd1, 8'($urandom)); wr(3'd2, 8'($urandom)); wr(3'd3, 8'($urandom));
      base = mon_q.size();
      wr(3'd0, 8'h01);
      m_busy = 1'b1;
      cyc = 0;
      while ((mon_q.size() - base) < 12 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_reach_byte2", (mon_q.size() - base) >= 12, 1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("rst_abort");
      @(negedge clk);
      reset_n = 1'b1;
      m_busy  = 1'b0;
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      go(1'b0, -1, 1'b0, "post_rst_zero");
      wr(3'd1, 8'h42); wr(3'd2, 8'h0C); wr(3'd3, 8'h9E);
      go(1'b0, -1, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
